echo_tap_scheduler: RTL and testbench



---
 rtl/echo_pkg.sv | 28 ++
 rtl/echo_rd_pipe.sv | 60 ++++++
 rtl/echo_tap_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_echo_tap_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// ---------------------------------------------------------------------------
// echo_pkg
// Shared definitions for the echo ring-buffer scheduler:
//   - scheduler state encoding
//   - default ring-buffer geometry and datapath width
//   - default tap delays (0.125 / 0.25 / 0.375 s at 44.1 kHz)
// ---------------------------------------------------------------------------
package echo_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;
    localparam int NTAPS_DEF  = 3;
    localparam int RD_LAT_DEF = 1;

    localparam logic [ADDR_W_DEF-1:0] TAP_DELAY_0 = 15'd5512;
    localparam logic [ADDR_W_DEF-1:0] TAP_DELAY_1 = 15'd11025;
    localparam logic [ADDR_W_DEF-1:0] TAP_DELAY_2 = 15'd16538;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_CLEAR = 3'd5
    } echo_state_e;

endpackage

// File: rtl/echo_rd_pipe.sv
// ---------------------------------------------------------------------------
// echo_rd_pipe
// RD_LAT-deep shift register carrying {valid, idx, zero_flag} for each read
// slot so the tap strobe lines up with the BRAM read data. Disabled taps ride
// the pipe with zero_flag set and come out with data forced to 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset (flushes pipe)
//   issue_valid_i       a tap slot is being issued this cycle
//   issue_idx_i         index of the issued tap
//   issue_zero_i        tap is disabled: output data must be 0
//   mem_dout_i          BRAM read data (valid RD_LAT cycles after issue)
//   tap_valid_o         aligned tap strobe
//   tap_idx_o           aligned tap index (0 when not valid)
//   tap_data_o          tap sample (0 when not valid or tap disabled)
// ---------------------------------------------------------------------------
module echo_rd_pipe #(
    parameter int DATA_W = 16,
    parameter int TAP_W  = 2,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid_i,
    input  logic [TAP_W-1:0]  issue_idx_i,
    input  logic              issue_zero_i,
    input  logic [DATA_W-1:0] mem_dout_i,
    output logic              tap_valid_o,
    output logic [TAP_W-1:0]  tap_idx_o,
    output logic [DATA_W-1:0] tap_data_o
);

    logic [RD_LAT-1:0]            vld_q;
    logic [RD_LAT-1:0]            zero_q;
    logic [RD_LAT-1:0][TAP_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            zero_q <= '0;
            idx_q  <= '0;
        end else begin
            vld_q[0]  <= issue_valid_i;
            zero_q[0] <= issue_zero_i;
            idx_q[0]  <= issue_idx_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                zero_q[i] <= zero_q[i-1];
                idx_q[i]  <= idx_q[i-1];
            end
        end
    end

    always_comb begin
        tap_valid_o = vld_q[RD_LAT-1];
        tap_idx_o   = vld_q[RD_LAT-1] ? idx_q[RD_LAT-1] : '0;
        tap_data_o  = (vld_q[RD_LAT-1] && !zero_q[RD_LAT-1]) ? mem_dout_i : '0;
    end

endmodule

// File: rtl/echo_tap_scheduler.sv
// ---------------------------------------------------------------------------
// echo_tap_scheduler
// Sole master of the single-port echo ring-buffer BRAM. For every accepted
// sample: one write at wr_ptr, then one read slot per tap at
// (wr_ptr - delay_i), taps returned in index order, then frame_done.
//
// Build option: RINGBUF_CLEAR_EN -- after reset, sweep zeros through the
// whole ring buffer (CLEAR state) before accepting samples.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   sample_valid/ready/in      input sample handshake and data
//   tap_delay, tap_enable      per-tap delay / enable, latched on accept
//   mem_en/we/addr/din/dout    BRAM port
//   tap_valid/idx/data         delayed tap samples to the mixer
//   frame_done                 pulse after the last tap of a frame
//   wr_ptr                     address of the next sample write
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a sample
// WRITE | write latched sample at wr_ptr
// READ  | one tap slot per cycle (read if enabled, idle slot otherwise)
// DRAIN | wait RD_LAT cycles for the last read data
// DONE  | frame_done, advance wr_ptr
// CLEAR | zero-fill sweep after reset (RINGBUF_CLEAR_EN builds only)
// ---------------------------------------------------------------------------
module echo_tap_scheduler
    import echo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NTAPS  = NTAPS_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int TAP_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic [DATA_W-1:0]       sample_in,
    input  logic [NTAPS*ADDR_W-1:0] tap_delay,
    input  logic [NTAPS-1:0]        tap_enable,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_din,
    input  logic [DATA_W-1:0]       mem_dout,
    output logic                    tap_valid,
    output logic [TAP_W-1:0]        tap_idx,
    output logic [DATA_W-1:0]       tap_data,
    output logic                    frame_done,
    output logic [ADDR_W-1:0]       wr_ptr
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_WRITE = ST_WRITE;
    localparam logic [2:0] S_READ  = ST_READ;
    localparam logic [2:0] S_DRAIN = ST_DRAIN;
    localparam logic [2:0] S_DONE  = ST_DONE;
`ifdef RINGBUF_CLEAR_EN
    localparam logic [2:0] S_CLEAR = ST_CLEAR;
    localparam logic [2:0] S_RESET = S_CLEAR;
`else
    localparam logic [2:0] S_RESET = S_IDLE;
`endif

    localparam logic [TAP_W-1:0] LAST_SLOT  = TAP_W'(NTAPS - 1);
    localparam logic [1:0]       DRAIN_INIT = 2'(RD_LAT - 1);

    logic [2:0]              state_q,  state_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]       sample_q, sample_d;
    logic [NTAPS*ADDR_W-1:0] delay_q,  delay_d;
    logic [NTAPS-1:0]        en_q,     en_d;
    logic [TAP_W-1:0]        slot_q,   slot_d;
    logic [1:0]              drain_q,  drain_d;
`ifdef RINGBUF_CLEAR_EN
    logic [ADDR_W-1:0]       clr_q,    clr_d;
`endif

    logic [ADDR_W-1:0] cur_delay;
    logic              cur_en;
    logic              issue_valid;
    logic              issue_zero;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        sample_d = sample_q;
        delay_d  = delay_q;
        en_d     = en_q;
        slot_d   = slot_q;
        drain_d  = drain_q;
`ifdef RINGBUF_CLEAR_EN
        clr_d    = clr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    sample_d = sample_in;
                    delay_d  = tap_delay;
                    en_d     = tap_enable;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                slot_d  = '0;
                state_d = S_READ;
            end
            S_READ: begin
                if (slot_q == LAST_SLOT) begin
                    drain_d = DRAIN_INIT;
                    state_d = S_DRAIN;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            S_DONE: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                state_d  = S_IDLE;
            end
`ifdef RINGBUF_CLEAR_EN
            S_CLEAR: begin
                if (clr_q == '1) begin
                    state_d = S_IDLE;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RESET;
            wr_ptr_q <= '0;
            sample_q <= '0;
            delay_q  <= '0;
            en_q     <= '0;
            slot_q   <= '0;
            drain_q  <= '0;
`ifdef RINGBUF_CLEAR_EN
            clr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            sample_q <= sample_d;
            delay_q  <= delay_d;
            en_q     <= en_d;
            slot_q   <= slot_d;
            drain_q  <= drain_d;
`ifdef RINGBUF_CLEAR_EN
            clr_q    <= clr_d;
`endif
        end
    end

    // Select the latched delay/enable of the tap owning the current slot.
    always_comb begin
        cur_delay = '0;
        cur_en    = 1'b0;
        for (int i = 0; i < NTAPS; i++) begin
            if (slot_q == TAP_W'(i)) begin
                cur_delay = delay_q[i*ADDR_W +: ADDR_W];
                cur_en    = en_q[i];
            end
        end
    end

    always_comb begin
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_din     = '0;
        issue_valid = 1'b0;
        issue_zero  = 1'b0;
        case (state_q)
            S_WRITE: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = wr_ptr_q;
                mem_din  = sample_q;
            end
            S_READ: begin
                // A disabled tap still consumes its slot and emits a zero pulse.
                issue_valid = 1'b1;
                if (cur_en) begin
                    mem_en   = 1'b1;
                    mem_addr = wr_ptr_q - cur_delay;
                end else begin
                    issue_zero = 1'b1;
                end
            end
`ifdef RINGBUF_CLEAR_EN
            S_CLEAR: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_q;
            end
`endif
            default: ;
        endcase
    end

    assign sample_ready = (state_q == S_IDLE);
    assign frame_done   = (state_q == S_DONE);
    assign wr_ptr       = wr_ptr_q;

    echo_rd_pipe #(
        .DATA_W (DATA_W),
        .TAP_W  (TAP_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk           (clk),
        .reset         (reset),
        .issue_valid_i (issue_valid),
        .issue_idx_i   (slot_q),
        .issue_zero_i  (issue_zero),
        .mem_dout_i    (mem_dout),
        .tap_valid_o   (tap_valid),
        .tap_idx_o     (tap_idx),
        .tap_data_o    (tap_data)
    );

endmodule

// File: tb/tb_echo_tap_scheduler.sv
// ---------------------------------------------------------------------------
// tb_echo_tap_scheduler
// Scheduler on a 16-deep ring buffer with a behavioural BRAM. A reference
// ring-buffer array predicts tap data and read addresses per frame; each
// frame's outputs are captured cycle-by-cycle relative to the accept cycle.
// ---------------------------------------------------------------------------
module tb_echo_tap_scheduler;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int NTAPS  = 3;
    localparam int RD_LAT = 1;
    localparam int TAP_W  = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CYC    = 3 + NTAPS + RD_LAT;
`ifdef RINGBUF_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    sample_valid = 1'b0;
    logic                    sample_ready;
    logic [DATA_W-1:0]       sample_in = '0;
    logic [NTAPS*ADDR_W-1:0] tap_delay = '0;
    logic [NTAPS-1:0]        tap_enable = '0;
    logic                    mem_en, mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_din, mem_dout;
    logic                    tap_valid;
    logic [TAP_W-1:0]        tap_idx;
    logic [DATA_W-1:0]       tap_data;
    logic                    frame_done;
    logic [ADDR_W-1:0]       wr_ptr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    echo_tap_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NTAPS(NTAPS), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_in(sample_in),
        .tap_delay(tap_delay), .tap_enable(tap_enable),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout),
        .tap_valid(tap_valid), .tap_idx(tap_idx), .tap_data(tap_data),
        .frame_done(frame_done), .wr_ptr(wr_ptr)
    );

    // Behavioural BRAM, preloaded with a recognisable pattern.
    localparam logic [DATA_W-1:0] PRESET [DEPTH] = '{
        16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006, 16'hA007,
        16'hA008, 16'hA009, 16'hA00A, 16'hA00B, 16'hA00C, 16'hA00D, 16'hA00E, 16'hA00F};
    logic [DATA_W-1:0] bram [DEPTH] = PRESET;
    logic [DATA_W-1:0] rd_sr [RD_LAT];

    always @(posedge clk) begin
        if (mem_en && mem_we) bram[mem_addr] <= mem_din;
        rd_sr[0] <= (mem_en && !mem_we) ? bram[mem_addr] : 16'hDEAD;
        for (int i = 1; i < RD_LAT; i++) rd_sr[i] <= rd_sr[i-1];
    end
    assign mem_dout = rd_sr[RD_LAT-1];

    // Reference model state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [ADDR_W-1:0] ref_wp;
    logic [ADDR_W-1:0] exp_addr [NTAPS];
    logic [DATA_W-1:0] exp_data [NTAPS];
    logic [ADDR_W-1:0] exp_wp;

    // Per-frame capture, index c = cycles after the accept cycle
    logic              o_en [CYC+1], o_we [CYC+1], o_tv [CYC+1], o_done [CYC+1], o_ready [CYC+1];
    logic [ADDR_W-1:0] o_addr [CYC+1], o_wp [CYC+1];
    logic [DATA_W-1:0] o_din [CYC+1], o_data [CYC+1];
    logic [TAP_W-1:0]  o_idx [CYC+1];

    task automatic model_frame(input logic [DATA_W-1:0] s, input logic [NTAPS*ADDR_W-1:0] d,
                               input logic [NTAPS-1:0] e);
        ref_mem[ref_wp] = s;
        exp_wp = ref_wp;
        for (int k = 0; k < NTAPS; k++) begin
            exp_addr[k] = ref_wp - d[k*ADDR_W +: ADDR_W];
            exp_data[k] = e[k] ? ref_mem[exp_addr[k]] : '0;
        end
        ref_wp = ref_wp + 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ref_wp = '0;
        if (CLR) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic wait_ready(input string tag);
        int budget = 0;
        while (!sample_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        vectors++;
        if (sample_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_timeout got=%b want=1", tag, sample_ready);
        end
    endtask

    // Offer one sample and capture outputs for CYC cycles after the accept.
    // chg: scramble inputs and hold sample_valid high while the frame runs.
    task automatic run_frame(input logic [DATA_W-1:0] s, input logic [NTAPS*ADDR_W-1:0] d,
                             input logic [NTAPS-1:0] e, input bit chg);
        @(negedge clk);
        wait_ready("run_frame");
        sample_in = s; tap_delay = d; tap_enable = e; sample_valid = 1'b1;
        for (int c = 1; c <= CYC; c++) begin
            @(negedge clk);
            if (c == 1 && chg) begin
                tap_delay = 12'($urandom); tap_enable = 3'($urandom); sample_in = 16'($urandom);
            end
            if (!chg || c == CYC) sample_valid = 1'b0;
            o_en[c] = mem_en; o_we[c] = mem_we; o_addr[c] = mem_addr; o_din[c] = mem_din;
            o_tv[c] = tap_valid; o_idx[c] = tap_idx; o_data[c] = tap_data;
            o_done[c] = frame_done; o_ready[c] = sample_ready; o_wp[c] = wr_ptr;
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (sample_ready !== !CLR) begin miscompares++; $display("FAIL reset sample_ready got=%b want=%b", sample_ready, !CLR); end
        vectors++; if (mem_en !== CLR) begin miscompares++; $display("FAIL reset mem_en got=%b want=%b", mem_en, CLR); end
        vectors++; if (mem_we !== CLR) begin miscompares++; $display("FAIL reset mem_we got=%b want=%b", mem_we, CLR); end
        vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL reset mem_addr got=%h want=0", mem_addr); end
        vectors++; if (mem_din !== '0) begin miscompares++; $display("FAIL reset mem_din got=%h want=0", mem_din); end
        vectors++; if (tap_valid !== 1'b0 || tap_idx !== '0 || tap_data !== '0) begin
            miscompares++; $display("FAIL reset tap got v=%b i=%0d d=%h want 0/0/0", tap_valid, tap_idx, tap_data); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset frame_done got=%b want=0", frame_done); end
        vectors++; if (wr_ptr !== '0) begin miscompares++; $display("FAIL reset wr_ptr got=%0d want=0", wr_ptr); end
    endtask

    // Full cycle-by-cycle check of one default frame.
    task automatic test_first_frame();
        logic [NTAPS*ADDR_W-1:0] d = {4'd3, 4'd2, 4'd1};
        logic [NTAPS-1:0] e = 3'b111;
        logic [DATA_W-1:0] s = 16'h1111;
        bit rd, tv, x_en;
        int k, p;
        logic [ADDR_W-1:0] x_addr, x_wp;
        logic [DATA_W-1:0] x_din, x_data;
        model_frame(s, d, e);
        run_frame(s, d, e, 1'b0);
        for (int c = 1; c <= CYC; c++) begin
            k = c - 2; p = c - 2 - RD_LAT;
            rd = (c >= 2 && c <= 1 + NTAPS);
            tv = (p >= 0 && p < NTAPS);
            x_en = (c == 1) || rd;
            x_addr = (c == 1) ? exp_wp : (rd ? exp_addr[k] : '0);
            x_din = (c == 1) ? s : '0;
            x_data = tv ? exp_data[p] : '0;
            x_wp = (c == CYC) ? exp_wp + 1'b1 : exp_wp;
            vectors++; if (o_en[c] !== x_en) begin miscompares++; $display("FAIL first c%0d mem_en got=%b want=%b", c, o_en[c], x_en); end
            vectors++; if (o_we[c] !== (c == 1)) begin miscompares++; $display("FAIL first c%0d mem_we got=%b want=%b", c, o_we[c], c == 1); end
            vectors++; if (o_addr[c] !== x_addr) begin miscompares++; $display("FAIL first c%0d mem_addr got=%h want=%h", c, o_addr[c], x_addr); end
            vectors++; if (o_din[c] !== x_din) begin miscompares++; $display("FAIL first c%0d mem_din got=%h want=%h", c, o_din[c], x_din); end
            vectors++; if (o_tv[c] !== tv) begin miscompares++; $display("FAIL first c%0d tap_valid got=%b want=%b", c, o_tv[c], tv); end
            vectors++; if (o_idx[c] !== (tv ? TAP_W'(p) : '0)) begin miscompares++; $display("FAIL first c%0d tap_idx got=%0d want=%0d", c, o_idx[c], tv ? p : 0); end
            vectors++; if (o_data[c] !== x_data) begin miscompares++; $display("FAIL first c%0d tap_data got=%h want=%h", c, o_data[c], x_data); end
            vectors++; if (o_done[c] !== (c == 2 + NTAPS + RD_LAT)) begin miscompares++; $display("FAIL first c%0d frame_done got=%b", c, o_done[c]); end
            vectors++; if (o_ready[c] !== (c == CYC)) begin miscompares++; $display("FAIL first c%0d sample_ready got=%b want=%b", c, o_ready[c], c == CYC); end
            vectors++; if (o_wp[c] !== x_wp) begin miscompares++; $display("FAIL first c%0d wr_ptr got=%0d want=%0d", c, o_wp[c], x_wp); end
        end
    endtask

    // Samples 1..20 with delays 1/2/3 across the 15 -> 0 wrap.
    task automatic test_wrap();
        logic [NTAPS*ADDR_W-1:0] d = {4'd3, 4'd2, 4'd1};
        int c;
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            model_frame(DATA_W'(n), d, 3'b111);
            run_frame(DATA_W'(n), d, 3'b111, 1'b0);
            for (int k = 0; k < NTAPS; k++) begin
                c = 2 + k + RD_LAT;
                vectors++;
                if (o_tv[c] !== 1'b1 || o_idx[c] !== TAP_W'(k) || o_data[c] !== exp_data[k]) begin
                    miscompares++;
                    $display("FAIL wrap n%0d tap%0d got v=%b i=%0d d=%h want v=1 i=%0d d=%h",
                             n, k, o_tv[c], o_idx[c], o_data[c], k, exp_data[k]);
                end
            end
            vectors++;
            if (o_wp[CYC] !== exp_wp + 1'b1) begin
                miscompares++; $display("FAIL wrap n%0d wr_ptr got=%0d want=%0d", n, o_wp[CYC], exp_wp + 1'b1);
            end
        end
    endtask

    task automatic test_enable();
        logic [NTAPS*ADDR_W-1:0] d = {4'd3, 4'd2, 4'd1};
        logic [DATA_W-1:0] want;
        model_frame(16'h0B0B, d, 3'b010);
        run_frame(16'h0B0B, d, 3'b010, 1'b0);
        for (int k = 0; k < NTAPS; k++) begin
            vectors++;
            if (o_en[2+k] !== (k == 1)) begin
                miscompares++; $display("FAIL enable slot%0d mem_en got=%b want=%b", k, o_en[2+k], k == 1);
            end
            want = (k == 1) ? exp_data[1] : '0;
            vectors++;
            if (o_tv[2+k+RD_LAT] !== 1'b1 || o_idx[2+k+RD_LAT] !== TAP_W'(k) || o_data[2+k+RD_LAT] !== want) begin
                miscompares++;
                $display("FAIL enable tap%0d got v=%b i=%0d d=%h want v=1 i=%0d d=%h",
                         k, o_tv[2+k+RD_LAT], o_idx[2+k+RD_LAT], o_data[2+k+RD_LAT], k, want);
            end
        end
        vectors++;
        if (o_done[2+NTAPS+RD_LAT] !== 1'b1 || o_ready[CYC] !== 1'b1) begin
            miscompares++; $display("FAIL enable done got=%b ready=%b want 1/1", o_done[2+NTAPS+RD_LAT], o_ready[CYC]);
        end
    endtask

    // Tap 0 at delay 0, inputs scrambled right after the accept.
    task automatic test_delay0();
        logic [NTAPS*ADDR_W-1:0] d = {4'd7, 4'd4, 4'd0};
        logic [DATA_W-1:0] s = 16'h5A5A;
        model_frame(s, d, 3'b111);
        run_frame(s, d, 3'b111, 1'b1);
        vectors++;
        if (o_data[2+RD_LAT] !== s) begin
            miscompares++; $display("FAIL delay0 tap0 data got=%h want=%h", o_data[2+RD_LAT], s);
        end
        for (int k = 0; k < NTAPS; k++) begin
            vectors++;
            if (o_addr[2+k] !== exp_addr[k] || o_data[2+k+RD_LAT] !== exp_data[k]) begin
                miscompares++;
                $display("FAIL delay0 tap%0d got a=%h d=%h want a=%h d=%h",
                         k, o_addr[2+k], o_data[2+k+RD_LAT], exp_addr[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] s;
        logic [NTAPS*ADDR_W-1:0] d;
        logic [NTAPS-1:0] e;
        int pulses;
        for (int n = 0; n < 30; n++) begin
            s = 16'($urandom); d = 12'($urandom); e = 3'($urandom);
            model_frame(s, d, e);
            run_frame(s, d, e, 1'($urandom));
            pulses = 0;
            for (int c = 1; c <= CYC; c++) pulses += int'(o_tv[c]);
            vectors++;
            if (pulses != NTAPS) begin
                miscompares++; $display("FAIL random n%0d pulses got=%0d want=%0d", n, pulses, NTAPS);
            end
            for (int k = 0; k < NTAPS; k++) begin
                vectors++;
                if (o_en[2+k] !== e[k] || (e[k] && o_addr[2+k] !== exp_addr[k])) begin
                    miscompares++;
                    $display("FAIL random n%0d slot%0d got en=%b a=%h want en=%b a=%h",
                             n, k, o_en[2+k], o_addr[2+k], e[k], exp_addr[k]);
                end
                vectors++;
                if (o_idx[2+k+RD_LAT] !== TAP_W'(k) || o_data[2+k+RD_LAT] !== exp_data[k]) begin
                    miscompares++;
                    $display("FAIL random n%0d tap%0d got i=%0d d=%h want i=%0d d=%h",
                             n, k, o_idx[2+k+RD_LAT], o_data[2+k+RD_LAT], k, exp_data[k]);
                end
            end
            vectors++;
            if (o_done[2+NTAPS+RD_LAT] !== 1'b1 || o_wp[CYC] !== exp_wp + 1'b1) begin
                miscompares++;
                $display("FAIL random n%0d done=%b wr_ptr=%0d want 1/%0d", n, o_done[2+NTAPS+RD_LAT], o_wp[CYC], exp_wp + 1'b1);
            end
        end
    endtask

    // Reset asserted during the first READ slot aborts the frame.
    task automatic test_reset_mid();
        logic [NTAPS*ADDR_W-1:0] d = {4'd3, 4'd2, 4'd1};
        @(negedge clk);
        wait_ready("reset_mid");
        sample_in = 16'hC0DE; tap_delay = d; tap_enable = 3'b111; sample_valid = 1'b1;
        ref_mem[ref_wp] = 16'hC0DE;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (sample_ready !== !CLR) begin miscompares++; $display("FAIL reset_mid sample_ready got=%b want=%b", sample_ready, !CLR); end
        vectors++; if (tap_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid tap_valid got=%b want=0", tap_valid); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_mid frame_done got=%b want=0", frame_done); end
        vectors++; if (wr_ptr !== '0) begin miscompares++; $display("FAIL reset_mid wr_ptr got=%0d want=0", wr_ptr); end
        reset = 1'b0;
        ref_wp = '0;
        if (CLR) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            vectors++;
            if (tap_valid !== 1'b0 || frame_done !== 1'b0 || wr_ptr !== '0) begin
                miscompares++;
                $display("FAIL reset_mid after c%0d got v=%b done=%b wp=%0d want 0/0/0", c, tap_valid, frame_done, wr_ptr);
            end
        end
        // The aborted frame's write landed; a following frame must see it.
        model_frame(16'h0042, {4'd0, 4'd15, 4'd1}, 3'b111);
        run_frame(16'h0042, {4'd0, 4'd15, 4'd1}, 3'b111, 1'b0);
        for (int k = 0; k < NTAPS; k++) begin
            vectors++;
            if (o_data[2+k+RD_LAT] !== exp_data[k]) begin
                miscompares++; $display("FAIL reset_mid post tap%0d got=%h want=%h", k, o_data[2+k+RD_LAT], exp_data[k]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = PRESET[i];
        ref_wp = '0;
        test_reset();
        test_first_frame();
        test_wrap();
        test_enable();
        test_delay0();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
